// File: rtl/disk_pkg.sv
// Shared constants and the loader state type for the Disk II track buffer.
package disk_pkg;

  localparam int TRACK_BYTES  = 6656;
  localparam int SECTOR_BYTES = 512;
  localparam int MAX_TRACK    = 34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_XFER,
    ST_RD_REQ,
    ST_RD_XFER
  } loader_state_t;

endpackage

// File: rtl/track_ram.sv
// 8192x8 true dual-port synchronous RAM on one clock.
// Port A serves the drive, port B the block-storage side.
module track_ram (
  input  logic        CLK_14M,
  input  logic        RESET_N,
  input  logic [12:0] addr_a,
  input  logic [7:0]  din_a,
  input  logic        we_a,
  output logic [7:0]  dout_a,
  input  logic [12:0] addr_b,
  input  logic [7:0]  din_b,
  input  logic        we_b,
  output logic [7:0]  dout_b
);

  logic [7:0] mem [0:8191];

  // Contents survive reset; only the read registers are cleared.
  always_ff @(posedge CLK_14M) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
  end

  always_ff @(posedge CLK_14M) begin
    if (!RESET_N) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/disk_track_loader.sv
// Track buffer between the Disk II drive model and block storage: loads a
// nibble track per head move. DISK_TRACK_WRITEBACK_EN adds dirty-track flush.
//
// state      | meaning
// IDLE       | serving the drive, watching TRACK and mounts
// WB_REQ     | requesting write of one sector of the old track
// WB_XFER    | storage reading that sector out of the buffer
// RD_REQ     | requesting read of one sector of the target track
// RD_XFER    | storage writing that sector into the buffer
module disk_track_loader
  import disk_pkg::*;
#(
  parameter int SECTORS_PER_TRACK = 13,
  parameter int LBA_W             = 32
) (
  input  logic             CLK_14M,
  input  logic             RESET_N,
  input  logic             IMG_MOUNTED,
  output logic             DISK_READY,
  input  logic [5:0]       TRACK,
  input  logic [12:0]      TRACK_ADDR,
  input  logic [7:0]       TRACK_DI,
  input  logic             TRACK_WE,
  output logic [7:0]       TRACK_DO,
  output logic             TRACK_BUSY,
  output logic [LBA_W-1:0] SD_LBA,
  output logic             SD_RD,
  output logic             SD_WR,
  input  logic             SD_ACK,
  input  logic [8:0]       SD_BUFF_ADDR,
  input  logic [7:0]       SD_BUFF_DOUT,
  input  logic             SD_BUFF_WR,
  output logic [7:0]       SD_BUFF_DIN
);

`ifdef DISK_TRACK_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  loader_state_t state, state_nx;
  logic [5:0] cur_track, cur_track_nx, target, target_nx;
  logic [3:0] sector, sector_nx;
  logic       valid, valid_nx, dirty, dirty_nx;
  logic       mount_seen, mount_seen_nx, mounted;
  logic       ack_q, rd_q, wr_q;
  logic       ack_fall, last_sector, mount_pend, drive_we;
  logic [7:0] ram_q_b;

  assign TRACK_BUSY  = ~valid | (TRACK != cur_track) | (state != ST_IDLE);
  assign DISK_READY  = valid;
  assign drive_we    = TRACK_WE & ~TRACK_BUSY & RESET_N;
  assign ack_fall    = ack_q & ~SD_ACK;
  assign last_sector = (sector == 4'(SECTORS_PER_TRACK - 1));
  assign mount_pend  = mount_seen | IMG_MOUNTED;
  assign SD_RD       = rd_q & RESET_N;

  always_comb begin
    state_nx      = state;
    cur_track_nx  = cur_track;
    target_nx     = target;
    sector_nx     = sector;
    valid_nx      = valid;
    dirty_nx      = dirty;
    mount_seen_nx = mount_seen;
    if (drive_we) dirty_nx = 1'b1;
    case (state)
      ST_IDLE: begin
        if (mount_seen) begin
          valid_nx      = 1'b0;
          dirty_nx      = 1'b0;
          mount_seen_nx = 1'b0;
        end
        if (mounted && (!(valid && !mount_seen) || TRACK != cur_track)) begin
          state_nx  = (dirty && !mount_seen) ? ST_WB_REQ : ST_RD_REQ;
          sector_nx = '0;
          target_nx = TRACK;
        end
      end
      ST_WB_REQ: if (SD_ACK) state_nx = ST_WB_XFER;
      ST_RD_REQ: if (SD_ACK) state_nx = ST_RD_XFER;
      ST_WB_XFER: if (ack_fall) begin
        if (mount_pend) begin
          valid_nx = 1'b0;
          dirty_nx = 1'b0;
          state_nx = ST_IDLE;
        end else if (last_sector) begin
          // Flush is done; load whatever the head wants now.
          dirty_nx  = 1'b0;
          sector_nx = '0;
          target_nx = TRACK;
          state_nx  = ST_RD_REQ;
        end else begin
          sector_nx = sector + 4'd1;
          state_nx  = ST_WB_REQ;
        end
      end
      ST_RD_XFER: if (ack_fall) begin
        if (mount_pend) begin
          valid_nx = 1'b0;
          dirty_nx = 1'b0;
          state_nx = ST_IDLE;
        end else if (TRACK != target) begin
          sector_nx = '0;
          target_nx = TRACK;
          state_nx  = ST_RD_REQ;
        end else if (last_sector) begin
          cur_track_nx = target;
          valid_nx     = 1'b1;
          state_nx     = ST_IDLE;
        end else begin
          sector_nx = sector + 4'd1;
          state_nx  = ST_RD_REQ;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (IMG_MOUNTED) mount_seen_nx = 1'b1;
    dirty_nx = dirty_nx & WB_EN;
  end

  always_ff @(posedge CLK_14M) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      cur_track  <= '0;
      target     <= '0;
      sector     <= '0;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      mount_seen <= 1'b0;
      mounted    <= 1'b0;
      ack_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      SD_LBA     <= '0;
    end else begin
      state      <= state_nx;
      cur_track  <= cur_track_nx;
      target     <= target_nx;
      sector     <= sector_nx;
      valid      <= valid_nx;
      dirty      <= dirty_nx;
      mount_seen <= mount_seen_nx;
      ack_q      <= SD_ACK;
      if (IMG_MOUNTED) mounted <= 1'b1;
      rd_q <= (state == ST_RD_REQ) && !SD_ACK;
      wr_q <= (state == ST_WB_REQ) && !SD_ACK;
      if (state == ST_RD_REQ)
        SD_LBA <= LBA_W'(target) * LBA_W'(SECTORS_PER_TRACK) + LBA_W'(sector);
      else if (state == ST_WB_REQ)
        SD_LBA <= LBA_W'(cur_track) * LBA_W'(SECTORS_PER_TRACK) + LBA_W'(sector);
    end
  end

  track_ram u_ram (
    .CLK_14M (CLK_14M),
    .RESET_N (RESET_N),
    .addr_a  (TRACK_ADDR),
    .din_a   (TRACK_DI),
    .we_a    (drive_we),
    .dout_a  (TRACK_DO),
    .addr_b  ({sector, SD_BUFF_ADDR}),
    .din_b   (SD_BUFF_DOUT),
    .we_b    (SD_BUFF_WR && state == ST_RD_XFER && RESET_N),
    .dout_b  (ram_q_b)
  );

`ifdef DISK_TRACK_WRITEBACK_EN
  assign SD_WR       = wr_q & RESET_N;
  assign SD_BUFF_DIN = ram_q_b;
`else
  logic unused_wb;
  assign unused_wb   = ^{ram_q_b, wr_q};
  assign SD_WR       = 1'b0;
  assign SD_BUFF_DIN = 8'h00;
`endif

endmodule

// File: tb/tb_disk_track_loader.sv
// Scoreboard bench for disk_track_loader: a storage model serves sector
// requests and checks them against queued expectations.
module tb_disk_track_loader;

  logic        CLK_14M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        IMG_MOUNTED = 1'b0;
  logic        DISK_READY;
  logic [5:0]  TRACK = '0;
  logic [12:0] TRACK_ADDR = '0;
  logic [7:0]  TRACK_DI = '0;
  logic        TRACK_WE = 1'b0;
  logic [7:0]  TRACK_DO;
  logic        TRACK_BUSY;
  logic [31:0] SD_LBA;
  logic        SD_RD, SD_WR;
  logic        SD_ACK = 1'b0;
  logic [8:0]  SD_BUFF_ADDR = '0;
  logic [7:0]  SD_BUFF_DOUT = '0;
  logic        SD_BUFF_WR = 1'b0;
  logic [7:0]  SD_BUFF_DIN;

  int checks = 0;
  int errors = 0;
  logic [32:0] sd_q[$];
  logic [7:0]  rd_exp_q[$];
  logic        rd_check = 1'b0;

  disk_track_loader #(.SECTORS_PER_TRACK(13), .LBA_W(32)) dut (
    .CLK_14M(CLK_14M), .RESET_N(RESET_N), .IMG_MOUNTED(IMG_MOUNTED),
    .DISK_READY(DISK_READY), .TRACK(TRACK), .TRACK_ADDR(TRACK_ADDR),
    .TRACK_DI(TRACK_DI), .TRACK_WE(TRACK_WE), .TRACK_DO(TRACK_DO),
    .TRACK_BUSY(TRACK_BUSY), .SD_LBA(SD_LBA), .SD_RD(SD_RD), .SD_WR(SD_WR),
    .SD_ACK(SD_ACK), .SD_BUFF_ADDR(SD_BUFF_ADDR), .SD_BUFF_DOUT(SD_BUFF_DOUT),
    .SD_BUFF_WR(SD_BUFF_WR), .SD_BUFF_DIN(SD_BUFF_DIN)
  );

  always #5 CLK_14M = ~CLK_14M;

  function automatic logic [7:0] exp_byte(input int lba, input int a);
    return 8'((lba * 37 + a * 5 + 11) & 255);
  endfunction

  // Track 3 as loaded, with the drive's 0xD5 patched into its last byte.
  function automatic logic [7:0] wb_exp(input int lba, input int a);
    return (lba == 51 && a == 511) ? 8'hD5 : exp_byte(lba, a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Storage model and request monitor.
  initial begin : sd_host
    logic        is_wr;
    logic [31:0] lba;
    int          prev;
    bit          aborted;
    int          addrs [4];
    addrs = '{0, 1, 255, 511};
    prev = 0;
    forever begin
      @(posedge CLK_14M); #1;
      if (RESET_N && (SD_RD || SD_WR)) begin
        is_wr = SD_WR;
        lba   = SD_LBA;
        if (sd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sd_req actual wr=%0d lba=%0d required none", is_wr, lba);
        end else begin
          chk("sd_req", {31'd0, is_wr, lba}, {31'd0, sd_q.pop_front()});
        end
        SD_ACK  = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i <= 4 && !aborted; i++) begin
          @(posedge CLK_14M); #1;
          if (!RESET_N) aborted = 1'b1;
          else begin
            if (is_wr && i > 0) chk("wb_byte", SD_BUFF_DIN, wb_exp(lba, prev));
            if (i < 4) begin
              SD_BUFF_ADDR = 9'(addrs[i]);
              prev         = addrs[i];
              SD_BUFF_DOUT = exp_byte(lba, addrs[i]);
              SD_BUFF_WR   = !is_wr;
            end else SD_BUFF_WR = 1'b0;
          end
        end
        SD_BUFF_WR = 1'b0;
        SD_ACK     = 1'b0;
      end
    end
  end

  // Drive-read monitor.
  always @(negedge CLK_14M) begin
    if (rd_check) begin
      if (rd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL track_do actual=%0h required none", TRACK_DO);
      end else chk("track_do", TRACK_DO, rd_exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge CLK_14M); #2;
  endtask

  task automatic drv_rd(input logic [12:0] a, input logic [7:0] e);
    step(); TRACK_ADDR = a;
    step(); rd_exp_q.push_back(e); rd_check = 1'b1;
    step(); rd_check = 1'b0;
  endtask

  task automatic drv_wr(input logic [12:0] a, input logic [7:0] d);
    step(); TRACK_ADDR = a; TRACK_DI = d; TRACK_WE = 1'b1;
    step(); TRACK_WE = 1'b0;
  endtask

  task automatic push_rd(input int first, input int last);
    for (int i = first; i <= last; i++) sd_q.push_back({1'b0, 32'(i)});
  endtask

  task automatic wait_idle(input string name, output bit dropped);
    int n;
    n = 0; dropped = 1'b0;
    step();
    while (TRACK_BUSY && n < 2000) begin
      if (!DISK_READY) dropped = 1'b1;
      step(); n++;
    end
    chk(name, TRACK_BUSY, 0);
  endtask

  task automatic wait_ack_lba(input int lba);
    int n;
    n = 0;
    while (!(SD_ACK && SD_LBA == 32'(lba)) && n < 2000) begin step(); n++; end
    chk("reach_lba", SD_LBA, 64'(lba));
  endtask

  task automatic pulse_mount();
    step(); IMG_MOUNTED = 1'b1;
    step(); IMG_MOUNTED = 1'b0;
  endtask

  initial begin : stim
    bit dropped;
    repeat (3) step();
    chk("rst_busy", TRACK_BUSY, 1);
    chk("rst_ready", DISK_READY, 0);
    chk("rst_sd_rd", SD_RD, 0);
    chk("rst_sd_wr", SD_WR, 0);
    chk("rst_lba", SD_LBA, 0);
    chk("rst_do", TRACK_DO, 0);
    chk("rst_din", SD_BUFF_DIN, 0);
    RESET_N = 1'b1;
    repeat (4) step();
    chk("unmounted_busy", TRACK_BUSY, 1);

    // Mount, load track 0.
    push_rd(0, 12);
    pulse_mount();
    wait_idle("load_t0", dropped);
    chk("ready_t0", DISK_READY, 1);
    chk("q_t0", sd_q.size(), 0);
    drv_rd(13'h0200, exp_byte(1, 0));
    drv_rd(13'h0000, exp_byte(0, 0));
    drv_rd(13'h18FF, exp_byte(12, 255));

    // Clean move to track 3; a write while busy must be dropped.
    push_rd(39, 51);
    step(); TRACK = 6'd3; #1;
    chk("busy_comb", TRACK_BUSY, 1);
    wait_ack_lba(45);
    drv_wr(13'h0000, 8'hEE);
    wait_idle("load_t3", dropped);
    chk("ready_kept", dropped, 0);
    chk("q_t3", sd_q.size(), 0);
    drv_rd(13'h0000, exp_byte(39, 0));

    // Dirty move to track 4.
    drv_wr(13'h19FF, 8'hD5);
    drv_rd(13'h19FF, 8'hD5);
`ifdef DISK_TRACK_WRITEBACK_EN
    for (int i = 39; i <= 51; i++) sd_q.push_back({1'b1, 32'(i)});
`endif
    push_rd(52, 64);
    step(); TRACK = 6'd4;
    wait_idle("load_t4", dropped);
    chk("q_t4", sd_q.size(), 0);
    drv_rd(13'h19FF, exp_byte(64, 511));

    // Head moves again while sector 4 of track 5 is loading.
    push_rd(65, 69);
    push_rd(78, 90);
    step(); TRACK = 6'd5;
    wait_ack_lba(69);
    TRACK = 6'd6;
    wait_idle("load_t6", dropped);
    chk("q_t6", sd_q.size(), 0);
    drv_rd(13'h0000, exp_byte(78, 0));

    // Out-of-track write, then remount with a dirty buffer.
    drv_wr(13'h1A10, 8'hA5);
    drv_rd(13'h1A10, 8'hA5);
    push_rd(78, 90);
    pulse_mount();
    step(); step();
    chk("ready_mount", DISK_READY, 0);
    wait_idle("reload_mount", dropped);
    chk("q_mount", sd_q.size(), 0);
    chk("ready_remount", DISK_READY, 1);
    drv_rd(13'h0000, exp_byte(78, 0));

    // Reset in the middle of a sector transfer.
    push_rd(91, 92);
    step(); TRACK = 6'd7;
    wait_ack_lba(92);
    step();
    RESET_N = 1'b0;
    step();
    chk("rst_mid_rd", SD_RD, 0);
    chk("rst_mid_busy", TRACK_BUSY, 1);
    chk("rst_mid_ready", DISK_READY, 0);
    step(); RESET_N = 1'b1;
    repeat (6) step();
    chk("post_rst_busy", TRACK_BUSY, 1);
    chk("q_rst", sd_q.size(), 0);
    push_rd(91, 103);
    pulse_mount();
    wait_idle("reload_rst", dropped);
    chk("q_reload", sd_q.size(), 0);
    chk("ready_reload", DISK_READY, 1);
    drv_rd(13'h0000, exp_byte(91, 0));

    repeat (4) step();
    chk("q_final", sd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
